// File: rtl/score_fnd_scan.sv
// BCD score counter with 1x/2x tick prescaler and a multiplexed, leading-zero-blanked FND driver.
// Optional high-score register and display select when SCORE_HISCORE_EN is defined.
module score_fnd_scan #(
  parameter int DIGITS   = 4,
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_DIV = 65536
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CLEAR,
  input  logic                  RUN,
  input  logic                  FAST,
`ifdef SCORE_HISCORE_EN
  input  logic                  HISCORE_SHOW,
  output logic [4*DIGITS-1:0]   HISCORE,
`endif
  output logic [4*DIGITS-1:0]   SCORE,
  output logic                  SAT,
  output logic [DIGITS-1:0]     FND_COM,
  output logic [7:0]            FND_DATA
);

  localparam int PW = $clog2(CLK_HZ) + 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]       HZ    = PW'(CLK_HZ);
  localparam logic [SW-1:0]       SMAX  = SW'(SCAN_DIV - 1);
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  logic [PW-1:0]       pres;
  logic [PW-1:0]       pres_nxt;
  logic                tick;
  logic [4*DIGITS-1:0] score;
  logic [4*DIGITS-1:0] score_inc;
  logic                carry;
  logic [SW-1:0]       scan_cnt;
  logic                scan_wrap;
  logic [IW-1:0]       pos;
  logic [4*DIGITS-1:0] disp;
  logic [DIGITS-1:0]   show;
  logic                nz;
  logic [3:0]          digit;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign pres_nxt = pres + (FAST ? PW'(2) : PW'(1));
  assign tick     = RUN && (pres_nxt >= HZ);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)   pres <= '0;
    else if (CLEAR) pres <= '0;
    else if (RUN)   pres <= tick ? '0 : pres_nxt;
  end

  always_comb begin
    score_inc = score;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = '0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign SAT   = (score == NINES);
  assign SCORE = score;

  // A tick at all-nines is dropped rather than wrapping to zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)          score <= '0;
    else if (CLEAR)        score <= '0;
    else if (tick && !SAT) score <= score_inc;
  end

`ifdef SCORE_HISCORE_EN
  logic [4*DIGITS-1:0] hiscore;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)            hiscore <= '0;
    else if (score > hiscore) hiscore <= score;
  end

  assign HISCORE = hiscore;
  assign disp    = HISCORE_SHOW ? hiscore : score;
`else
  assign disp    = score;
`endif

  assign scan_wrap = (scan_cnt == SMAX);

  // pos counts down so that DIGITS-1 (leftmost) is scanned first.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scan_cnt <= '0;
      pos      <= IW'(DIGITS - 1);
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      if (scan_wrap) pos <= (pos == '0) ? IW'(DIGITS - 1) : pos - IW'(1);
    end
  end

  always_comb begin
    nz   = 1'b0;
    show = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      nz = nz | (disp[4*(DIGITS-1-k) +: 4] != 4'd0);
      show[DIGITS-1-k] = nz;
    end
    show[0] = 1'b1;
  end

  assign digit = disp[{pos, 2'b00} +: 4];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FND_COM  <= DIGITS'(1) << (DIGITS - 1);
      FND_DATA <= 8'hFF;
    end else begin
      FND_COM  <= DIGITS'(1) << pos;
      FND_DATA <= show[pos] ? seg7(digit) : 8'hFF;
    end
  end

endmodule
